// File: rtl/flipdot_frame_receiver.sv
// flipdot_frame_receiver: 8N1 UART receiver plus flipdot panel frame parser.
// Bytes are deserialised from rxd and parsed as start, command, address,
// NUM_COLS column bytes and end. Each 7-bit column is written out through
// col_we/col_addr/col_data. Everything runs on uclk.
module flipdot_frame_receiver #(
   parameter int         CLKS_PER_BIT = 16,
   parameter int         NUM_COLS     = 28,
   parameter logic [7:0] PANEL_ADDR   = 8'h00
) (
   input  logic       uclk,
   input  logic       reset,
   input  logic       rxd,
   output logic       col_we,
   output logic [4:0] col_addr,
   output logic [6:0] col_data,
   output logic       frame_valid,
   output logic       refresh,
   output logic       frame_err,
   output logic       busy
);

   localparam int             CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [4:0]     COL_LAST  = 5'(NUM_COLS - 1);

   localparam logic [7:0] BYTE_SOF   = 8'h80;
   localparam logic [7:0] BYTE_REF   = 8'h83;
   localparam logic [7:0] BYTE_NOREF = 8'h84;
   localparam logic [7:0] BYTE_EOF   = 8'h8F;
   localparam logic [7:0] BYTE_BCAST = 8'hFF;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {P_HUNT, P_CMD, P_ADDR, P_DATA, P_END, P_SKIP} p_state_t;

   // Line conditioning: synchroniser stages and the edge-detect copy.
   logic rxd_s1_q, rxd_s2_q, rxd_prev_q;

   // UART receiver state.
   rx_state_t         rx_state_q, rx_state_d;
   logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              byte_rdy_q, byte_rdy_d;
   logic              stop_err_q, stop_err_d;

   // Parser state and registered outputs.
   p_state_t          p_state_q, p_state_d;
   logic              cmd_ref_q, cmd_ref_d;
   logic [4:0]        col_cnt_q, col_cnt_d;
   logic              col_we_q, col_we_d;
   logic [4:0]        col_addr_q, col_addr_d;
   logic [6:0]        col_data_q, col_data_d;
   logic              fv_q, fv_d;
   logic              refresh_q, refresh_d;
   logic              perr_q, perr_d;

   // Synchronise rxd; all stages reset to the idle-high line level.
   always_ff @(posedge uclk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         rxd_s1_q   <= 1'b1;
         rxd_s2_q   <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_s1_q   <= rxd;
         rxd_s2_q   <= rxd_s1_q;
         rxd_prev_q <= rxd_s2_q;
      end
   end

   // UART receiver next-state: start-bit qualification, LSB-first shift, stop check.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch can be inferred.
      rx_state_d = rx_state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      byte_rdy_d = 1'b0;
      stop_err_d = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            if (rxd_prev_q && !rxd_s2_q) begin
               rx_state_d = RX_START;
               clk_cnt_d  = '0;
               bit_cnt_d  = '0;
            end
         end
         RX_START: begin
            if (clk_cnt_q == HALF_LAST) begin
               clk_cnt_d  = '0;
               rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               shift_d   = {rxd_s2_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d  = '0;
               rx_state_d = RX_IDLE;
               if (rxd_s2_q) begin
                  byte_rdy_d = 1'b1;
               end else begin
                  stop_err_d = 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // UART receiver registers.
   always_ff @(posedge uclk) begin
      if (reset) begin
         rx_state_q <= RX_IDLE;
         clk_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         byte_rdy_q <= 1'b0;
         stop_err_q <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         byte_rdy_q <= byte_rdy_d;
         stop_err_q <= stop_err_d;
      end
   end

   // Parser next-state: advances on each received byte; a stop-bit error forces hunt.
   always_comb begin
      p_state_d  = p_state_q;
      cmd_ref_d  = cmd_ref_q;
      col_cnt_d  = col_cnt_q;
      col_we_d   = 1'b0;
      col_addr_d = col_addr_q;
      col_data_d = col_data_q;
      fv_d       = 1'b0;
      refresh_d  = 1'b0;
      perr_d     = 1'b0;
      if (stop_err_q) begin
         p_state_d = P_HUNT;
      end else if (byte_rdy_q) begin
         unique case (p_state_q)
            P_HUNT: begin
               if (shift_q == BYTE_SOF) p_state_d = P_CMD;
            end
            P_CMD: begin
               if (shift_q == BYTE_REF || shift_q == BYTE_NOREF) begin
                  cmd_ref_d = (shift_q == BYTE_REF);
                  p_state_d = P_ADDR;
               end else begin
                  perr_d    = 1'b1;
                  p_state_d = P_HUNT;
               end
            end
            P_ADDR: begin
               if (shift_q == PANEL_ADDR || shift_q == BYTE_BCAST) begin
                  col_cnt_d = '0;
                  p_state_d = P_DATA;
               end else begin
                  p_state_d = P_SKIP;
               end
            end
            P_DATA: begin
               if (!shift_q[7]) begin
                  col_we_d   = 1'b1;
                  col_addr_d = col_cnt_q;
                  col_data_d = shift_q[6:0];
                  if (col_cnt_q == COL_LAST) begin
                     p_state_d = P_END;
                  end else begin
                     col_cnt_d = col_cnt_q + 1'b1;
                  end
               end else begin
                  // A start byte mid-frame resyncs straight onto the new frame.
                  perr_d    = 1'b1;
                  p_state_d = (shift_q == BYTE_SOF) ? P_CMD : P_HUNT;
               end
            end
            P_END: begin
               if (shift_q == BYTE_EOF) begin
                  fv_d      = 1'b1;
                  refresh_d = cmd_ref_q;
               end else begin
                  perr_d = 1'b1;
               end
               p_state_d = P_HUNT;
            end
            P_SKIP: begin
               if (shift_q == BYTE_EOF) begin
                  p_state_d = P_HUNT;
               end else if (shift_q == BYTE_SOF) begin
                  p_state_d = P_CMD;
               end
            end
            default: p_state_d = P_HUNT;
         endcase
      end
   end

   // Parser registers and registered output strobes.
   always_ff @(posedge uclk) begin
      if (reset) begin
         p_state_q  <= P_HUNT;
         cmd_ref_q  <= 1'b0;
         col_cnt_q  <= '0;
         col_we_q   <= 1'b0;
         col_addr_q <= '0;
         col_data_q <= '0;
         fv_q       <= 1'b0;
         refresh_q  <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         p_state_q  <= p_state_d;
         cmd_ref_q  <= cmd_ref_d;
         col_cnt_q  <= col_cnt_d;
         col_we_q   <= col_we_d;
         col_addr_q <= col_addr_d;
         col_data_q <= col_data_d;
         fv_q       <= fv_d;
         refresh_q  <= refresh_d;
         perr_q     <= perr_d;
      end
   end

   assign col_we      = col_we_q;
   assign col_addr    = col_addr_q;
   assign col_data    = col_data_q;
   assign frame_valid = fv_q;
   assign refresh     = refresh_q;
   assign frame_err   = perr_q | stop_err_q;
   assign busy        = (p_state_q == P_CMD) || (p_state_q == P_ADDR) ||
                        (p_state_q == P_DATA) || (p_state_q == P_END);

endmodule

// File: tb/tb_flipdot_frame_receiver.sv
// Directed testbench for flipdot_frame_receiver: drives 8N1 frames on rxd
// and checks column writes, frame_valid/refresh, frame_err and busy.
module tb_flipdot_frame_receiver;

   localparam int CPB  = 16;
   localparam int NCOL = 28;

   logic       uclk  = 1'b0;
   logic       reset = 1'b1;
   logic       rxd   = 1'b1;
   logic       col_we;
   logic [4:0] col_addr;
   logic [6:0] col_data;
   logic       frame_valid;
   logic       refresh;
   logic       frame_err;
   logic       busy;

   int checks    = 0;
   int errors    = 0;
   int fv_cnt    = 0;
   int fe_cnt    = 0;
   int excl_cnt  = 0;
   logic last_refresh = 1'b0;
   logic [4:0] wr_addr[$];
   logic [6:0] wr_data[$];

   flipdot_frame_receiver #(
      .CLKS_PER_BIT(CPB),
      .NUM_COLS    (NCOL),
      .PANEL_ADDR  (8'h00)
   ) dut (
      .uclk       (uclk),
      .reset      (reset),
      .rxd        (rxd),
      .col_we     (col_we),
      .col_addr   (col_addr),
      .col_data   (col_data),
      .frame_valid(frame_valid),
      .refresh    (refresh),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 uclk = ~uclk;

   // Record every strobe on the falling edge, away from the active edge.
   always @(negedge uclk) begin
      if (col_we) begin
         wr_addr.push_back(col_addr);
         wr_data.push_back(col_data);
      end
      if (frame_valid) begin
         fv_cnt++;
         last_refresh = refresh;
      end
      if (frame_err) fe_cnt++;
      if (int'(col_we) + int'(frame_valid) + int'(frame_err) > 1) excl_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      repeat (CPB) @(negedge uclk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_bit);
   endtask

   // Column i carries (i ^ mask) in its low 7 bits.
   task automatic send_cols(input int n, input logic [6:0] mask);
      for (int i = 0; i < n; i++) send_byte({1'b0, 7'(i) ^ mask});
   endtask

   task automatic idle(input int n_bits);
      rxd = 1'b1;
      repeat (n_bits * CPB) @(negedge uclk);
      #1;
   endtask

   task automatic check_cols(input string tag, input int base, input int n, input logic [6:0] mask);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[base + i]), 32'(i));
         check($sformatf("%s_data%0d", tag, i), 32'(wr_data[base + i]), 32'(7'(i) ^ mask));
      end
   endtask

   int base, fv0, fe0;

   initial begin
      // Reset state.
      repeat (4) @(negedge uclk);
      check("rst_col_we", col_we, 0);
      check("rst_col_addr", col_addr, 0);
      check("rst_col_data", col_data, 0);
      check("rst_frame_valid", frame_valid, 0);
      check("rst_refresh", refresh, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      idle(2);

      // Frame 1: 80 83 00 {00..1B} 8F.
      base = wr_addr.size(); fv0 = fv_cnt; fe0 = fe_cnt;
      send_byte(8'h80);
      check("f1_busy_after_sof", busy, 1);
      send_byte(8'h83);
      send_byte(8'h00);
      send_cols(NCOL, 7'h00);
      send_byte(8'h8F);
      idle(2);
      check("f1_writes", wr_addr.size() - base, NCOL);
      check_cols("f1", base, NCOL, 7'h00);
      check("f1_fv", fv_cnt - fv0, 1);
      check("f1_refresh", last_refresh, 1);
      check("f1_fe", fe_cnt - fe0, 0);
      check("f1_busy_end", busy, 0);

      // Frame 2: command 84, broadcast address.
      base = wr_addr.size(); fv0 = fv_cnt; fe0 = fe_cnt;
      send_byte(8'h80); send_byte(8'h84); send_byte(8'hFF);
      send_cols(NCOL, 7'h00);
      send_byte(8'h8F);
      idle(2);
      check("f2_writes", wr_addr.size() - base, NCOL);
      check_cols("f2", base, NCOL, 7'h00);
      check("f2_fv", fv_cnt - fv0, 1);
      check("f2_refresh", last_refresh, 0);
      check("f2_fe", fe_cnt - fe0, 0);

      // Frame 3: foreign address 05 is skipped silently.
      base = wr_addr.size(); fv0 = fv_cnt; fe0 = fe_cnt;
      send_byte(8'h80); send_byte(8'h83); send_byte(8'h05);
      check("f3_busy_skip", busy, 0);
      send_cols(NCOL, 7'h00);
      send_byte(8'h8F);
      idle(2);
      check("f3_writes", wr_addr.size() - base, 0);
      check("f3_fv", fv_cnt - fv0, 0);
      check("f3_fe", fe_cnt - fe0, 0);
      check("f3_busy_end", busy, 0);

      // Frame 4: column 10 replaced by 80, which starts a full valid frame.
      base = wr_addr.size(); fv0 = fv_cnt; fe0 = fe_cnt;
      send_byte(8'h80); send_byte(8'h83); send_byte(8'h00);
      send_cols(10, 7'h00);
      send_byte(8'h80);
      check("f4_busy_resync", busy, 1);
      send_byte(8'h83); send_byte(8'h00);
      send_cols(NCOL, 7'h2A);
      send_byte(8'h8F);
      idle(2);
      check("f4_writes", wr_addr.size() - base, 10 + NCOL);
      check_cols("f4a", base, 10, 7'h00);
      check_cols("f4b", base + 10, NCOL, 7'h2A);
      check("f4_fe", fe_cnt - fe0, 1);
      check("f4_fv", fv_cnt - fv0, 1);
      check("f4_refresh", last_refresh, 1);

      // Frame 5: stop bit low on the third column byte.
      base = wr_addr.size(); fv0 = fv_cnt; fe0 = fe_cnt;
      send_byte(8'h80); send_byte(8'h83); send_byte(8'h00);
      send_cols(2, 7'h00);
      send_byte(8'h02, 1'b0);
      idle(3);
      check("f5_writes", wr_addr.size() - base, 2);
      check("f5_fe", fe_cnt - fe0, 1);
      check("f5_fv", fv_cnt - fv0, 0);
      check("f5_busy_hunt", busy, 0);

      // Quarter-bit low glitch on an idle line.
      base = wr_addr.size(); fv0 = fv_cnt; fe0 = fe_cnt;
      rxd = 1'b0;
      repeat (CPB / 4) @(negedge uclk);
      idle(3);
      check("gl_writes", wr_addr.size() - base, 0);
      check("gl_fe", fe_cnt - fe0, 0);
      check("gl_busy", busy, 0);

      // Reset for one cycle after column 5, then a correct frame.
      base = wr_addr.size(); fv0 = fv_cnt; fe0 = fe_cnt;
      send_byte(8'h80); send_byte(8'h83); send_byte(8'h00);
      send_cols(6, 7'h00);
      check("rs_busy_before", busy, 1);
      check("rs_writes_before", wr_addr.size() - base, 6);
      reset = 1'b1;
      @(negedge uclk);
      reset = 1'b0;
      check("rs_col_we", col_we, 0);
      check("rs_col_addr", col_addr, 0);
      check("rs_col_data", col_data, 0);
      check("rs_frame_err", frame_err, 0);
      check("rs_busy", busy, 0);
      idle(3);
      check("rs_no_writes", wr_addr.size() - base, 6);
      check("rs_fe", fe_cnt - fe0, 0);
      base = wr_addr.size(); fv0 = fv_cnt;
      send_byte(8'h80); send_byte(8'h83); send_byte(8'h00);
      send_cols(NCOL, 7'h55);
      send_byte(8'h8F);
      idle(2);
      check("rs_frame_writes", wr_addr.size() - base, NCOL);
      check_cols("rs", base, NCOL, 7'h55);
      check("rs_fv", fv_cnt - fv0, 1);
      check("rs_refresh", last_refresh, 1);
      check("rs_fe_total", fe_cnt - fe0, 0);

      check("strobe_exclusive", excl_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
